// File: rtl/rtc_alarm_ctrl.sv
// rtc_alarm_ctrl: APB seconds counter with NUM_CH one-shot/periodic match channels and a masked interrupt.
// Optional feature macro RTC_PRESCALE_EN: an internal prescaler at 0x80 replaces the rtc_tick input.
module rtc_alarm_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CH     = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  rtc_tick,
  output logic [DATA_WIDTH-1:0] rtc_count,
  output logic [NUM_CH-1:0]     ch_match,
  output logic                  RTCINTR
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] A_COUNT = 8'h00;
  localparam logic [7:0] A_CTRL  = 8'h04;
  localparam logic [7:0] A_RAW   = 8'h08;
  localparam logic [7:0] A_MASK  = 8'h0C;
  localparam logic [7:0] A_CLR   = 8'h10;
  localparam logic [7:0] A_MIS   = 8'h14;

  logic [DATA_WIDTH-1:0] count_reg;
  logic                  en_reg, freeze_reg, intr_reg;
  logic [NUM_CH-1:0]     arm_reg, raw_reg, mask_reg, pulse_reg;
  logic [DATA_WIDTH-1:0] match_reg  [NUM_CH];
  logic [DATA_WIDTH-1:0] period_reg [NUM_CH];

  logic [7:0]            addr;
  logic [2:0]            ch_idx;
  logic [CH_W-1:0]       ch_sel;
  logic                  ch_ok, sel_match, sel_period, mapped;
  logic                  apb_wr, wr_count, wr_ctrl, wr_mask, wr_clr, wr_match, wr_period;
  logic                  tick_src, tick_ok;
  logic [DATA_WIDTH-1:0] count_inc;
  logic [NUM_CH-1:0]     hit, clr_bits;
  logic                  unused_addr;

  assign addr        = PADDR[7:0];
  assign unused_addr = ^PADDR[ADDR_WIDTH-1:8];
  assign ch_idx      = addr[4:2];
  assign ch_sel      = ch_idx[CH_W-1:0];
  assign ch_ok       = (addr[1:0] == 2'b00) && ({29'd0, ch_idx} < 32'(NUM_CH));
  assign sel_match   = (addr[7:5] == 3'b001) && ch_ok;
  assign sel_period  = (addr[7:5] == 3'b010) && ch_ok;

  assign apb_wr    = PSEL && PENABLE && PWRITE;
  assign wr_count  = apb_wr && (addr == A_COUNT);
  assign wr_ctrl   = apb_wr && (addr == A_CTRL);
  assign wr_mask   = apb_wr && (addr == A_MASK);
  assign wr_clr    = apb_wr && (addr == A_CLR);
  assign wr_match  = apb_wr && sel_match;
  assign wr_period = apb_wr && sel_period;
  assign clr_bits  = wr_clr ? PWDATA[NUM_CH-1:0] : '0;

`ifdef RTC_PRESCALE_EN
  localparam logic [7:0] A_PRESCALE = 8'h80;
  logic [PRESCALE_W-1:0] prescale_reg, psc_cnt_reg;
  logic                  wr_prescale, unused_tick;

  assign wr_prescale = apb_wr && (addr == A_PRESCALE);
  assign unused_tick = rtc_tick;
  assign tick_src    = en_reg && (psc_cnt_reg == '0);

  // Down-counter sits at PRESCALE while disabled, so the first tick lands PRESCALE+1 cycles after EN.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prescale_reg <= '0;
      psc_cnt_reg  <= '0;
    end else begin
      if (wr_prescale) prescale_reg <= PWDATA[PRESCALE_W-1:0];
      if (!en_reg || psc_cnt_reg == '0) psc_cnt_reg <= prescale_reg;
      else                              psc_cnt_reg <= psc_cnt_reg - PRESCALE_W'(1);
    end
  end
`else
  assign tick_src = rtc_tick;
`endif

  // A COUNT write in the same cycle drops the tick, so loads never produce a match.
  assign tick_ok   = tick_src && en_reg && !freeze_reg && !wr_count;
  assign count_inc = count_reg + DATA_WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_hit
      assign hit[gi] = tick_ok && arm_reg[gi] && (count_inc == match_reg[gi]);
    end
  endgenerate

  always_comb begin
    mapped = sel_match || sel_period;
    case (addr)
      A_COUNT, A_CTRL, A_RAW, A_MASK, A_CLR, A_MIS: mapped = 1'b1;
`ifdef RTC_PRESCALE_EN
      A_PRESCALE: mapped = 1'b1;
`endif
      default: ;
    endcase
  end

  // Software writes to MATCH/CTRL take priority over a reload or disarm from a coincident hit.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      arm_reg <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        match_reg[c]  <= '0;
        period_reg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_period && ch_sel == CH_W'(c)) period_reg[c] <= PWDATA;
        if (wr_match && ch_sel == CH_W'(c)) begin
          match_reg[c] <= PWDATA;
          arm_reg[c]   <= 1'b1;
        end else begin
          if (hit[c] && period_reg[c] != '0) match_reg[c] <= match_reg[c] + period_reg[c];
          if (wr_ctrl)                            arm_reg[c] <= PWDATA[8+c];
          else if (hit[c] && period_reg[c] == '0) arm_reg[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      count_reg  <= '0;
      en_reg     <= 1'b0;
      freeze_reg <= 1'b0;
      raw_reg    <= '0;
      mask_reg   <= '0;
      pulse_reg  <= '0;
      intr_reg   <= 1'b0;
    end else begin
      if (wr_count)     count_reg <= PWDATA;
      else if (tick_ok) count_reg <= count_inc;
      if (wr_ctrl) begin
        en_reg     <= PWDATA[0];
        freeze_reg <= PWDATA[1];
      end
      if (wr_mask) mask_reg <= PWDATA[NUM_CH-1:0];
      raw_reg   <= (raw_reg & ~clr_bits) | hit;
      pulse_reg <= hit;
      intr_reg  <= |(raw_reg & mask_reg);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (sel_match)       PRDATA = match_reg[ch_sel];
      else if (sel_period) PRDATA = period_reg[ch_sel];
      else begin
        case (addr)
          A_COUNT: PRDATA = count_reg;
          A_CTRL: begin
            PRDATA[0]           = en_reg;
            PRDATA[1]           = freeze_reg;
            PRDATA[8 +: NUM_CH] = arm_reg;
          end
          A_RAW:  PRDATA[NUM_CH-1:0] = raw_reg;
          A_MASK: PRDATA[NUM_CH-1:0] = mask_reg;
          A_MIS:  PRDATA[NUM_CH-1:0] = raw_reg & mask_reg;
`ifdef RTC_PRESCALE_EN
          A_PRESCALE: PRDATA[PRESCALE_W-1:0] = prescale_reg;
`endif
          default: ;
        endcase
      end
    end
  end

  assign PREADY    = 1'b1;
  assign PSLVERR   = PSEL && PENABLE && !mapped;
  assign rtc_count = count_reg;
  assign ch_match  = pulse_reg;
  assign RTCINTR   = intr_reg;
endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Scoreboard bench for rtc_alarm_ctrl: a transaction-level model predicts reads, match pulses and RTCINTR.
`timescale 1ns/1ps
module tb_rtc_alarm_ctrl;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NC = 4;

  logic          PCLK = 1'b0, PRESET = 1'b1;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, rtc_tick = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA, rtc_count;
  logic          PREADY, PSLVERR, RTCINTR;
  logic [NC-1:0] ch_match;

  rtc_alarm_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .PRESCALE_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .rtc_tick(rtc_tick), .rtc_count(rtc_count), .ch_match(ch_match), .RTCINTR(RTCINTR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0, bad = 0, cyc = 0;
  int pulses[NC];
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NC-1:0] mask; } ev_t;
  typedef struct { logic [DW-1:0] data; logic err; logic [7:0] addr; } rd_t;
  typedef struct { int cyc; logic val; } iv_t;
  ev_t ev_q[$];
  rd_t rd_q[$];
  iv_t iv_q[$];

  // Reference model: register contents as software sees them
  logic [DW-1:0] m_count, m_match[NC], m_period[NC];
  logic          m_en, m_freeze;
  logic [NC-1:0] m_arm, m_raw, m_mask;

  task automatic m_reset();
    m_count = '0; m_en = 1'b0; m_freeze = 1'b0; m_arm = '0; m_raw = '0; m_mask = '0;
    for (int c = 0; c < NC; c++) begin m_match[c] = '0; m_period[c] = '0; end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [7:0] a, output logic err);
    logic [DW-1:0] d;
    d = '0; err = 1'b0;
    case (a)
      8'h00: d = m_count;
      8'h04: begin d[0] = m_en; d[1] = m_freeze; d[8 +: NC] = m_arm; end
      8'h08: d[NC-1:0] = m_raw;
      8'h0C: d[NC-1:0] = m_mask;
      8'h10: d = '0;
      8'h14: d[NC-1:0] = m_raw & m_mask;
      8'h20, 8'h24, 8'h28, 8'h2C: d = m_match[int'(a[3:2])];
      8'h40, 8'h44, 8'h48, 8'h4C: d = m_period[int'(a[3:2])];
      default: err = 1'b1;
    endcase
    return d;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [DW-1:0] d);
    case (a)
      8'h00: m_count = d;
      8'h04: begin m_en = d[0]; m_freeze = d[1]; m_arm = d[8 +: NC]; end
      8'h0C: m_mask = d[NC-1:0];
      8'h10: m_raw = m_raw & ~d[NC-1:0];
      8'h20, 8'h24, 8'h28, 8'h2C: begin m_match[int'(a[3:2])] = d; m_arm[int'(a[3:2])] = 1'b1; end
      8'h40, 8'h44, 8'h48, 8'h4C: m_period[int'(a[3:2])] = d;
      default: ;
    endcase
  endtask

  // One clock edge worth of effect: the tick is resolved first, then software's write overrides.
  task automatic m_step(input bit wr, input logic [7:0] a, input logic [DW-1:0] d, input bit tk);
    logic [NC-1:0] hits;
    logic          old_i, new_i;
    old_i = |(m_raw & m_mask);
    hits  = '0;
    if (tk && m_en && !m_freeze && !(wr && a == 8'h00)) begin
      m_count = m_count + 1;
      for (int c = 0; c < NC; c++)
        if (m_arm[c] && m_match[c] == m_count) begin
          hits[c] = 1'b1;
          if (m_period[c] == 0) m_arm[c] = 1'b0;
          else                  m_match[c] = m_match[c] + m_period[c];
        end
    end
    if (wr) m_write(a, d);
    m_raw = m_raw | hits;
    if (hits != 0) ev_q.push_back('{cyc, hits});
    new_i = |(m_raw & m_mask);
    if (new_i != old_i) begin
      iv_q.push_back('{cyc, old_i});
      iv_q.push_back('{cyc + 1, new_i});
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end else $display("ok %s = %0h", name, got);
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse, an interrupt check point or a read.
  always @(negedge PCLK) begin
    ev_t e;
    rd_t r;
    if (!PRESET) begin
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        e = ev_q.pop_front();
        total++; bad++;
        $display("FAIL match_missing: got no pulse, required ch_match=%b at cycle %0d", e.mask, e.cyc);
      end
      if (ch_match != '0) begin
        for (int c = 0; c < NC; c++) if (ch_match[c]) pulses[c]++;
        total++;
        if (ev_q.size() == 0) begin
          bad++;
          $display("FAIL match_unexpected: got ch_match=%b at cycle %0d, required none", ch_match, cyc);
        end else begin
          e = ev_q.pop_front();
          if (e.cyc != cyc || e.mask != ch_match) begin
            bad++;
            $display("FAIL match: got %b at cycle %0d, required %b at cycle %0d", ch_match, cyc, e.mask, e.cyc);
          end else $display("ok match ch_match=%b count=%0d", ch_match, rtc_count);
        end
      end
      while (iv_q.size() > 0 && iv_q[0].cyc <= cyc) begin
        total++;
        if (iv_q[0].cyc != cyc || RTCINTR !== iv_q[0].val) begin
          bad++;
          $display("FAIL rtcintr: got %b at cycle %0d, required %b at cycle %0d", RTCINTR, cyc, iv_q[0].val, iv_q[0].cyc);
        end
        void'(iv_q.pop_front());
      end
      if (PSEL && PENABLE && !PWRITE) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL read_unexpected: got read data %0h", PRDATA);
        end else begin
          r = rd_q.pop_front();
          if (PRDATA !== r.data || PSLVERR !== r.err) begin
            bad++;
            $display("FAIL read[%0h]: got data=%0h err=%b, required data=%0h err=%b", r.addr, PRDATA, PSLVERR, r.data, r.err);
          end else $display("ok read[%0h] data=%0h err=%b", r.addr, PRDATA, PSLVERR);
        end
      end
    end
  end

  task automatic do_tick();
    rtc_tick = 1'b1;
    @(posedge PCLK); #1;
    rtc_tick = 1'b0;
    m_step(1'b0, 8'h00, '0, 1'b1);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [DW-1:0] d, input bit tk);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = AW'(a); PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; rtc_tick = tk;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rtc_tick = 1'b0;
    m_step(1'b1, a, d, tk);
  endtask

  task automatic apb_read_exp(input logic [7:0] a, input logic [DW-1:0] d, input logic e);
    rd_q.push_back('{d, e, a});
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = AW'(a);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a);
    logic          e;
    logic [DW-1:0] d;
    d = m_read(a, e);
    apb_read_exp(a, d, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    addrs[17];
    logic [7:0]    a;
    logic [DW-1:0] d;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h2C,
              8'h40, 8'h44, 8'h48, 8'h4C, 8'h30, 8'h50, 8'h80};
    for (int c = 0; c < NC; c++) pulses[c] = 0;
    m_reset();

    // Reset state
    PSEL = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("reset_count", rtc_count, 0);
    chk("reset_ch_match", ch_match, 0);
    chk("reset_rtcintr", RTCINTR, 0);
    chk("reset_pslverr", PSLVERR, 0);
    chk("reset_prdata", PRDATA, 0);
    PSEL = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // Basic counting
    apb_write(8'h00, 100, 1'b0);
    apb_write(8'h04, 1, 1'b0);
    repeat (5) do_tick();
    apb_read_exp(8'h00, 105, 1'b0);

    // One-shot match on channel 0, then no rematch after a reload
    apb_write(8'h40, 0, 1'b0);
    apb_write(8'h0C, 1, 1'b0);
    apb_write(8'h20, 110, 1'b0);
    repeat (5) do_tick();
    apb_read_exp(8'h08, 1, 1'b0);
    apb_read_exp(8'h04, 1, 1'b0);
    apb_read_exp(8'h14, 1, 1'b0);
    chk("rtcintr_after_match", RTCINTR, 1);
    chk("ch0_pulses_oneshot", pulses[0], 1);
    apb_write(8'h00, 105, 1'b0);
    repeat (5) do_tick();
    apb_read_exp(8'h00, 110, 1'b0);
    chk("ch0_pulses_no_rematch", pulses[0], 1);
    apb_write(8'h10, 1, 1'b0);
    apb_read_exp(8'h08, 0, 1'b0);

    // Periodic channel 1
    apb_write(8'h44, 5, 1'b0);
    apb_write(8'h00, 0, 1'b0);
    apb_write(8'h24, 10, 1'b0);
    repeat (20) do_tick();
    apb_read_exp(8'h24, 25, 1'b0);
    apb_read_exp(8'h08, 2, 1'b0);
    chk("ch1_pulses_periodic", pulses[1], 3);
    apb_write(8'h04, 1, 1'b0);

    // Wrap into a match at zero
    apb_write(8'h00, 32'hFFFF_FFFF, 1'b0);
    apb_write(8'h28, 0, 1'b0);
    do_tick();
    apb_read_exp(8'h00, 0, 1'b0);
    apb_read_exp(8'h08, 6, 1'b0);

    // CLR coinciding with a new ch0 match, COUNT write coinciding with a tick
    apb_write(8'h00, 200, 1'b0);
    apb_write(8'h20, 201, 1'b0);
    apb_write(8'h10, 32'hF, 1'b1);
    apb_read_exp(8'h08, 1, 1'b0);
    apb_write(8'h00, 32'h1234, 1'b1);
    apb_read_exp(8'h00, 32'h1234, 1'b0);

    // Unmapped addresses
    apb_read_exp(8'h30, 0, 1'b1);
    apb_read_exp(8'h80, 0, 1'b1);
    apb_read_exp(8'h18, 0, 1'b1);
    apb_read_exp(8'h10, 0, 1'b0);

    // Randomized traffic against the model
    apb_write(8'h00, 0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) do_tick();
      else if (r < 8) begin
        a = addrs[$urandom_range(0, 16)];
        case (a)
          8'h00: d = DW'($urandom_range(0, 40));
          8'h04: begin
            d = '0;
            d[0] = ($urandom_range(0, 5) != 0);
            d[1] = ($urandom_range(0, 6) == 0);
            d[8 +: NC] = NC'($urandom_range(0, 15));
          end
          8'h0C, 8'h10: d = DW'($urandom_range(0, 15));
          8'h20, 8'h24, 8'h28, 8'h2C: d = DW'($urandom_range(0, 45));
          8'h40, 8'h44, 8'h48, 8'h4C: d = DW'($urandom_range(0, 6));
          default: d = $urandom;
        endcase
        apb_write(a, d, $urandom_range(0, 3) == 0);
      end else apb_read(addrs[$urandom_range(0, 16)]);
    end
    repeat (3) @(posedge PCLK);
    #1;
    chk("match_queue_drained", ev_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);

    // Reset during a pending match suppresses the pulse
    apb_write(8'h04, 1, 1'b0);
    apb_write(8'h00, 50, 1'b0);
    apb_write(8'h20, 51, 1'b0);
    rtc_tick = 1'b1;
    @(posedge PCLK); #1;
    rtc_tick = 1'b0;
    PRESET = 1'b1;
    #1;
    chk("midreset_ch_match", ch_match, 0);
    chk("midreset_count", rtc_count, 0);
    chk("midreset_rtcintr", RTCINTR, 0);
    m_reset();
    ev_q.delete();
    iv_q.delete();
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    apb_read_exp(8'h04, 0, 1'b0);
    apb_read_exp(8'h20, 0, 1'b0);
    repeat (2) @(posedge PCLK);
    #1;
    chk("final_read_queue_drained", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
